branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencing controller for conditional branches in the EX stage. It accepts one branch at a time over a valid/ready handshake and registers the operands. It drives a `branch_comp` instance with the correct signedness, decodes funct3 into a taken/not-taken decision and compares that against the fetch-stage prediction. On a mismatch it issues a redirect and a timed pipeline flush. It also owns a small 2-bit branch history table (BHT) that fetch reads for predictions.

## Interface
- `BHT_ENTRIES`, 16, number of 2-bit counters; power of two, ≥2.
- `FLUSH_CYCLES`, 2, number of cycles `flush_o` stays high after a mispredict; ≥1.
- `clk_i` in 1: the single clock; all state updates on the rising edge.
- `rst_n_i` in 1: reset, asynchronous assert, active-low.
- `valid_i` in 1: branch request present.
- `ready_o` out 1: controller can accept a request.
- `pc_i` in 32: PC of the branch.
- `imm_i` in 32: sign-extended B-type offset.
- `funct3_i` in 3: branch funct3.
- `rs1_i` in 32: first operand.
- `rs2_i` in 32: second operand.
- `pred_taken_i` in 1: prediction fetch used for this branch.
- `lookup_pc_i` in 32: fetch PC for prediction.
- `lookup_taken_o` out 1: prediction, combinational, equal to the MSB of the counter at `lookup_pc_i[log2(BHT_ENTRIES)+1:2]`.
- `resolved_o` out 1: one-cycle pulse, branch resolved.
- `taken_o` out 1: resolved direction; valid while `resolved_o`.
- `mispredict_o` out 1: one-cycle pulse, `taken_o != prediction`.
- `redirect_o` out 1: one-cycle pulse; fetch must load `redirect_pc_o`.
- `redirect_pc_o` out 32: correct next PC.
- `flush_o` out 1: squash IF/ID while high.
- `illegal_o` out 1: one-cycle pulse, funct3 was 010 or 011.

## Operation
- FSM states: IDLE, RESOLVE, FLUSH.
- **IDLE**
  - `ready_o`=1.
  - On `valid_i & ready_o`: capture pc, imm, funct3, rs1, rs2 and pred_taken, then go to RESOLVE.
- **RESOLVE**
  - `ready_o`=0. The registered rs1/rs2 drive `branch_comp` A/B.
  - `br_un` is driven 1 for BLT/BGE (signed) and 0 for BLTU/BGEU, per the `branch_comp` convention that BrUn=1 selects signed. For BEQ/BNE its value is don't care.
  - Taken decision by funct3:
    - 000 BEQ: Eq
    - 001 BNE: !Eq
    - 100 BLT: LT
    - 101 BGE: !LT
    - 110 BLTU: LT
    - 111 BGEU: !LT
    - 010/011: not taken, `illegal_o` pulses, BHT untouched, no mispredict.
  - Next PC arithmetic:
    - Target = pc+imm, modulo 2^32 (carry out discarded).
    - Fall-through = pc+4, also wrapping.
    - `redirect_pc_o` = target if taken, otherwise fall-through.
  - BHT update at the end of RESOLVE, on the entry indexed by pc[log2(BHT_ENTRIES)+1:2].
    - Saturating counter: +1 if taken, −1 if not.
    - Held at 11 (taken) and 00 (not taken).
  - Next state: FLUSH if mispredict, otherwise IDLE.
- **FLUSH**
  - `ready_o`=0 and `flush_o`=1.
  - A down-counter loaded with FLUSH_CYCLES−1 on entry; exit to IDLE when it reaches 0.
- A `valid_i` arriving while `ready_o`=0 is not accepted. The requester must hold it stable until accepted.
- **Lookup vs. update:** a lookup that hits the entry being updated in the same cycle returns the pre-update value.

## Timing
- Request accepted at edge T.
- `resolved_o`, `taken_o`, `mispredict_o`, `redirect_o`, `redirect_pc_o` and `illegal_o` are registered at edge T+1. They are valid for the single cycle T+1..T+2.
- `redirect_o` = `resolved_o & mispredict_o`.
- `flush_o` is high from edge T+1 for exactly FLUSH_CYCLES cycles.
- `ready_o` returns high at:
  - edge T+1 on a correct prediction, giving one branch per 2 cycles;
  - edge T+1+FLUSH_CYCLES after a mispredict.
- **Reset values:**
  - State IDLE; `ready_o`=1.
  - All pulses, `taken_o`, `flush_o` = 0; `redirect_pc_o` = 0.
  - All BHT counters = 01 (weakly not-taken).
  - Flush counter = 0.
- **Reset mid-operation:** asserting `rst_n_i` in RESOLVE or FLUSH clears immediately. No pending redirect, flush or BHT update survives.

## Structure
- Package `branch_pkg` holds:
  - the funct3 enum (BEQ…BGEU);
  - the FSM state enum;
  - the BHT counter reset constant `2'b01`.
- One sub-module, `branch_bht`: counter array, combinational read port, synchronous saturating write port, async reset.
- The controller instantiates `branch_bht` and `branch_comp`.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, pred=0 → at T+1: `taken_o`=1, `mispredict_o`=1, `redirect_pc_o`=0x120, `flush_o` high for 2 cycles, `ready_o` back at T+3.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1 → taken, no redirect, `ready_o` back at T+1. BLTU with the same operands and pred=0 → not taken, no redirect.
- BGEU, rs1=rs2=0x80000000, pc=0xFFFFFFF0, imm=0x20, pred=0 → taken, `redirect_pc_o`=0x00000010 (wrap).
- funct3=010 with pred=0 → `illegal_o` pulse, `taken_o`=0, no redirect, BHT entry unchanged.
- Three taken branches at pc=0x40 → counter goes 01→10→11→11 and `lookup_taken_o`(0x40)=1 after the first. A same-cycle lookup returns the old value.
- Assert `rst_n_i` during FLUSH → `flush_o`=0 and `ready_o`=1 immediately, BHT all 01.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolution block
package branch_pkg;
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESOLVE,
        S_FLUSH
    } state_e;

    localparam logic [1:0] BHT_RESET = 2'b01;
endpackage

// File: rtl/branch_bht.sv
// branch_bht: table of 2-bit saturating counters, combinational read, synchronous update
module branch_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IW = $clog2(ENTRIES)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic          rd_taken_o,
    input  logic          we_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic          wr_taken_i
);
    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cur, nxt;

    assign rd_taken_o = cnt_q[rd_idx_i][1];
    assign cur = cnt_q[wr_idx_i];
    assign nxt = wr_taken_i ? (cur == 2'b11 ? cur : cur + 2'b01)
                            : (cur == 2'b00 ? cur : cur - 2'b01);

    // Counters start weakly not-taken; the read port sees the pre-update value in the write cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= BHT_RESET;
        end else if (we_i) begin
            cnt_q[wr_idx_i] <= nxt;
        end
    end
endmodule

// File: rtl/branch_comp.sv
// branch_comp: equality and less-than comparator; br_un_i=1 selects a signed compare
module branch_comp (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        br_un_i,
    output logic        br_eq_o,
    output logic        br_lt_o
);
    assign br_eq_o = a_i == b_i;
    assign br_lt_o = br_un_i ? $signed(a_i) < $signed(b_i) : a_i < b_i;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves one conditional branch at a time, redirects and flushes on mispredict
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        pred_taken_i,
    input  logic [31:0] lookup_pc_i,
    output logic        lookup_taken_o,
    output logic        resolved_o,
    output logic        taken_o,
    output logic        mispredict_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o
);
    localparam int IW  = $clog2(BHT_ENTRIES);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    state_e         state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]    pc_q, imm_q, rs1_q, rs2_q;
    logic [2:0]     f3_q;
    logic           pred_q;
    logic           accept, resolving, illegal, taken, mispred;
    logic           br_un, br_eq, br_lt;
    logic           unused_lookup;

    assign ready_o       = state_q == S_IDLE;
    assign flush_o       = state_q == S_FLUSH;
    assign accept        = valid_i & ready_o;
    assign resolving     = state_q == S_RESOLVE;
    assign br_un         = f3_q == F3_BLT || f3_q == F3_BGE;
    assign illegal       = f3_q[2:1] == 2'b01;
    assign taken         = !illegal && ((f3_q[2] ? br_lt : br_eq) ^ f3_q[0]);
    assign mispred       = !illegal && taken != pred_q;
    assign unused_lookup = ^{lookup_pc_i[31:IW+2], lookup_pc_i[1:0]};

    branch_comp u_comp (
        .a_i     (rs1_q),
        .b_i     (rs2_q),
        .br_un_i (br_un),
        .br_eq_o (br_eq),
        .br_lt_o (br_lt)
    );

    branch_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_idx_i   (lookup_pc_i[IW+1:2]),
        .rd_taken_o (lookup_taken_o),
        .we_i       (resolving & ~illegal),
        .wr_idx_i   (pc_q[IW+1:2]),
        .wr_taken_i (taken)
    );

    // Next state and flush countdown; the counter is reloaded every RESOLVE cycle
    always_comb begin
        state_d     = state_q == S_IDLE    ? (accept ? S_RESOLVE : S_IDLE) :
                      state_q == S_RESOLVE ? (mispred ? S_FLUSH : S_IDLE) :
                      (flush_cnt_q == '0 ? S_IDLE : S_FLUSH);
        flush_cnt_d = resolving ? FLUSH_LOAD :
                      (flush_o && flush_cnt_q != '0) ? flush_cnt_q - FCW'(1) : flush_cnt_q;
    end

    // FSM state and flush counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Request capture and one-cycle result pulses registered at the end of RESOLVE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            f3_q          <= '0;
            pred_q        <= 1'b0;
            resolved_o    <= 1'b0;
            taken_o       <= 1'b0;
            mispredict_o  <= 1'b0;
            redirect_o    <= 1'b0;
            illegal_o     <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            if (accept) begin
                pc_q   <= pc_i;
                imm_q  <= imm_i;
                rs1_q  <= rs1_i;
                rs2_q  <= rs2_i;
                f3_q   <= funct3_i;
                pred_q <= pred_taken_i;
            end
            resolved_o   <= resolving;
            taken_o      <= resolving & taken;
            mispredict_o <= resolving & mispred;
            redirect_o   <= resolving & mispred;
            illegal_o    <= resolving & illegal;
            if (resolving) redirect_pc_o <= taken ? pc_q + imm_q : pc_q + 32'd4;
        end
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed and randomized checks against a behavioural branch/BHT model
module tb_branch_resolve_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] pc = '0, imm = '0, rs1 = '0, rs2 = '0, lookup_pc = '0;
    logic [2:0]  f3 = '0;
    logic        pred = 1'b0;
    logic        ready_o, lookup_taken_o, resolved_o, taken_o, mispredict_o, redirect_o, flush_o, illegal_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int errors = 0;

    logic [1:0]  bht_m [16];
    logic        exp_taken, exp_mis, exp_ill;
    logic [31:0] exp_pc;
    logic        o_rdy_mid, o_lk0, o_res, o_tak, o_mis, o_red, o_ill, o_flush1, o_pulse2, o_flush_end;
    logic [31:0] o_rpc;
    int          o_k, o_nf;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.BHT_ENTRIES(16), .FLUSH_CYCLES(FC)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .valid_i        (valid),
        .ready_o        (ready_o),
        .pc_i           (pc),
        .imm_i          (imm),
        .funct3_i       (f3),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .pred_taken_i   (pred),
        .lookup_pc_i    (lookup_pc),
        .lookup_taken_o (lookup_taken_o),
        .resolved_o     (resolved_o),
        .taken_o        (taken_o),
        .mispredict_o   (mispredict_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .flush_o        (flush_o),
        .illegal_o      (illegal_o)
    );

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] p);
        return int'((p >> 2) % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
    endtask

    task automatic apply_reset();
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one branch from an idle negedge and records what the DUT did; leaves the bench at an idle negedge
    task automatic drive(input logic [31:0] p, input logic [31:0] im, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic pr);
        int i;
        i         = idx_of(p);
        exp_ill   = op == 3'b010 || op == 3'b011;
        exp_taken = ref_taken(op, a, b);
        exp_mis   = !exp_ill && exp_taken != pr;
        exp_pc    = exp_taken ? p + im : p + 32'd4;
        pc = p; imm = im; f3 = op; rs1 = a; rs2 = b; pred = pr; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        o_rdy_mid = ready_o;
        o_lk0     = lookup_taken_o;
        @(negedge clk);
        o_res = resolved_o; o_tak = taken_o; o_mis = mispredict_o; o_red = redirect_o;
        o_ill = illegal_o; o_rpc = redirect_pc_o; o_flush1 = flush_o;
        o_k = 1; o_nf = 0; o_pulse2 = 1'b0;
        while (!ready_o && o_k < 40) begin
            o_nf += int'(flush_o);
            @(negedge clk);
            o_k++;
            if (o_k == 2) o_pulse2 = resolved_o | mispredict_o | redirect_o | illegal_o;
        end
        if (o_k == 1) begin
            @(negedge clk);
            o_pulse2 = resolved_o | mispredict_o | redirect_o | illegal_o;
        end
        o_flush_end = flush_o;
        if (!exp_ill)
            bht_m[i] = exp_taken ? (bht_m[i] == 2'b11 ? 2'b11 : bht_m[i] + 2'b01)
                                 : (bht_m[i] == 2'b00 ? 2'b00 : bht_m[i] - 2'b01);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if ({resolved_o, taken_o, mispredict_o, redirect_o, flush_o, illegal_o} !== 6'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000000", {resolved_o, taken_o, mispredict_o, redirect_o, flush_o, illegal_o}); end
        checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc_o); end
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            checks++; if (lookup_taken_o !== 1'b0) begin errors++; $display("FAIL reset_bht[%0d]: got %b expected 0", i, lookup_taken_o); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_mispredict_beq();
        drive(32'h100, 32'h20, 3'b000, 32'h5, 32'h5, 1'b0);
        checks++; if (o_rdy_mid !== 1'b0) begin errors++; $display("FAIL beq_busy: ready got %b expected 0", o_rdy_mid); end
        checks++; if ({o_res, o_tak, o_mis, o_red} !== 4'b1111) begin errors++; $display("FAIL beq_flags: res/tak/mis/red got %b expected 1111", {o_res, o_tak, o_mis, o_red}); end
        checks++; if (o_rpc !== 32'h120) begin errors++; $display("FAIL beq_target: got %h expected 00000120", o_rpc); end
        checks++; if (o_nf !== FC || o_flush1 !== 1'b1) begin errors++; $display("FAIL beq_flush: cycles got %0d expected %0d", o_nf, FC); end
        checks++; if (o_k !== FC + 1) begin errors++; $display("FAIL beq_ready_return: got T+%0d expected T+%0d", o_k, FC + 1); end
        checks++; if (o_pulse2 !== 1'b0 || o_flush_end !== 1'b0) begin errors++; $display("FAIL beq_pulse_width: pulse %b flush %b expected 0 0", o_pulse2, o_flush_end); end
    endtask

    task automatic test_signedness();
        drive(32'h104, 32'h40, 3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1);
        checks++; if ({o_tak, o_mis, o_red} !== 3'b100) begin errors++; $display("FAIL blt_signed: tak/mis/red got %b expected 100", {o_tak, o_mis, o_red}); end
        checks++; if (o_k !== 1 || o_flush1 !== 1'b0) begin errors++; $display("FAIL blt_ready: got T+%0d flush %b expected T+1 flush 0", o_k, o_flush1); end
        checks++; if (o_rpc !== 32'h144) begin errors++; $display("FAIL blt_target: got %h expected 00000144", o_rpc); end
        drive(32'h108, 32'h40, 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0);
        checks++; if ({o_res, o_tak, o_mis, o_red} !== 4'b1000) begin errors++; $display("FAIL bltu_unsigned: res/tak/mis/red got %b expected 1000", {o_res, o_tak, o_mis, o_red}); end
        checks++; if (o_rpc !== 32'h10C) begin errors++; $display("FAIL bltu_fallthrough: got %h expected 0000010c", o_rpc); end
    endtask

    task automatic test_wrap();
        drive(32'hFFFF_FFF0, 32'h20, 3'b111, 32'h8000_0000, 32'h8000_0000, 1'b0);
        checks++; if ({o_tak, o_red} !== 2'b11) begin errors++; $display("FAIL bgeu_taken: tak/red got %b expected 11", {o_tak, o_red}); end
        checks++; if (o_rpc !== 32'h0000_0010) begin errors++; $display("FAIL bgeu_wrap: got %h expected 00000010", o_rpc); end
    endtask

    task automatic test_illegal();
        lookup_pc = 32'h200;
        #1;
        checks++; if (lookup_taken_o !== 1'b1) begin errors++; $display("FAIL illegal_pre_bht: got %b expected 1", lookup_taken_o); end
        for (int n = 0; n < 2; n++) begin
            drive(32'h200, 32'h8, n == 0 ? 3'b010 : 3'b011, 32'h1, 32'h1, n == 1);
            checks++; if ({o_res, o_ill, o_tak, o_mis, o_red} !== 5'b11000) begin
                errors++; $display("FAIL illegal_flags[%0d]: res/ill/tak/mis/red got %b expected 11000", n, {o_res, o_ill, o_tak, o_mis, o_red}); end
            checks++; if (o_k !== 1) begin errors++; $display("FAIL illegal_ready[%0d]: got T+%0d expected T+1", n, o_k); end
            checks++; if (lookup_taken_o !== 1'b1) begin errors++; $display("FAIL illegal_bht[%0d]: got %b expected 1", n, lookup_taken_o); end
        end
    endtask

    task automatic test_bht();
        logic [7:0] pat;
        logic       exp_old;
        apply_reset();
        lookup_pc = 32'h40;
        pat = 8'b1000_0111;
        for (int n = 0; n < 8; n++) begin
            exp_old = bht_m[0][1];
            drive(32'h40, 32'h10, 3'b000, 32'h7, pat[n] ? 32'h7 : 32'h8, exp_old);
            checks++; if (o_lk0 !== exp_old) begin errors++; $display("FAIL bht_same_cycle[%0d]: got %b expected %b", n, o_lk0, exp_old); end
            checks++; if (lookup_taken_o !== bht_m[0][1]) begin errors++; $display("FAIL bht_after[%0d]: got %b expected %b", n, lookup_taken_o, bht_m[0][1]); end
            if (n < 3) begin
                checks++; if (lookup_taken_o !== 1'b1) begin errors++; $display("FAIL bht_train[%0d]: got %b expected 1", n, lookup_taken_o); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(32'h44, 32'h10, 3'b000, 32'h3, 32'h3, 1'b1);
        pc = 32'h44; imm = 32'h10; f3 = 3'b000; rs1 = 32'h3; rs2 = 32'h3; pred = 1'b0; valid = 1'b1;
        lookup_pc = 32'h44;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (flush_o !== 1'b1 || lookup_taken_o !== 1'b1) begin errors++; $display("FAIL midrst_setup: flush %b bht %b expected 1 1", flush_o, lookup_taken_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (flush_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL midrst_flush: flush %b ready %b expected 0 1", flush_o, ready_o); end
        checks++; if ({resolved_o, redirect_o, mispredict_o} !== 3'b0 || redirect_pc_o !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs: pulses %b pc %h expected 000 0", {resolved_o, redirect_o, mispredict_o}, redirect_pc_o); end
        checks++; if (lookup_taken_o !== 1'b0) begin errors++; $display("FAIL midrst_bht: got %b expected 0", lookup_taken_o); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pc = 32'h48; f3 = 3'b000; rs1 = 32'h1; rs2 = 32'h1; pred = 1'b0; valid = 1'b1;
        lookup_pc = 32'h48;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (lookup_taken_o !== 1'b0 || resolved_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL resolve_rst: bht %b resolved %b ready %b expected 0 0 1", lookup_taken_o, resolved_o, ready_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, p, im, lp;
        logic [2:0]  op;
        logic        pr;
        for (int n = 0; n < 60; n++) begin
            p  = $urandom & 32'hFFFF_FFFC;
            im = $urandom & 32'hFFFF_FFFE;
            op = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
            b  = $urandom_range(0, 2) == 0 ? a : $urandom;
            pr = $urandom_range(0, 1) == 1 ? bht_m[idx_of(p)][1] : 1'($urandom_range(0, 1));
            drive(p, im, op, a, b, pr);
            checks++; if (o_rdy_mid !== 1'b0 || o_res !== 1'b1) begin errors++; $display("FAIL rnd_handshake[%0d]: ready %b resolved %b expected 0 1", n, o_rdy_mid, o_res); end
            checks++; if ({o_tak, o_mis, o_red, o_ill} !== {exp_taken, exp_mis, exp_mis, exp_ill}) begin
                errors++; $display("FAIL rnd_flags[%0d] op %0d: tak/mis/red/ill got %b expected %b", n, op, {o_tak, o_mis, o_red, o_ill}, {exp_taken, exp_mis, exp_mis, exp_ill}); end
            checks++; if (o_rpc !== exp_pc) begin errors++; $display("FAIL rnd_redirect_pc[%0d]: got %h expected %h", n, o_rpc, exp_pc); end
            checks++; if (o_k !== (exp_mis ? FC + 1 : 1) || o_nf !== (exp_mis ? FC : 0) || o_flush1 !== exp_mis) begin
                errors++; $display("FAIL rnd_timing[%0d]: ready T+%0d flush %0d got, expected T+%0d flush %0d", n, o_k, o_nf, exp_mis ? FC + 1 : 1, exp_mis ? FC : 0); end
            checks++; if (o_pulse2 !== 1'b0 || o_flush_end !== 1'b0) begin errors++; $display("FAIL rnd_pulse_width[%0d]: pulse %b flush %b expected 0 0", n, o_pulse2, o_flush_end); end
            lp = $urandom_range(0, 1) == 1 ? p : $urandom;
            lookup_pc = lp;
            #1;
            checks++; if (lookup_taken_o !== bht_m[idx_of(lp)][1]) begin errors++; $display("FAIL rnd_lookup[%0d]: got %b expected %b", n, lookup_taken_o, bht_m[idx_of(lp)][1]); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mispredict_beq();
        test_signedness();
        test_wrap();
        test_illegal();
        test_bht();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within 500000 time units");
        $fatal(1);
    end
endmodule
